// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, ALU select codes, sequencer states and wait-counter width
package alu_ctrl_pkg;
    localparam int CNT_W = 4;
    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    typedef enum logic [2:0] {
        SEL_FWD = 3'b000,
        SEL_ADD = 3'b001,
        SEL_AND = 3'b010,
        SEL_OR  = 3'b011
    } alu_sel_e;
    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WRITE} state_e;
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: maps an opcode to ALU select, operand shaping and settling time
module alu_op_decoder
    import alu_ctrl_pkg::*;
#(
    parameter int FWD_WAIT   = 1,
    parameter int ADD_WAIT   = 2,
    parameter int LOGIC_WAIT = 1
) (
    input  logic [7:0]       i_opcode,
    output alu_sel_e         o_alu_select,
    output logic             o_negate_src2,
    output logic             o_use_imm,
    output logic             o_zero_src1,
    output logic [CNT_W-1:0] o_wait_cycles,
    output logic             o_illegal
);
    always_comb begin
        o_illegal     = i_opcode > OP_OR;
        o_alu_select  = (i_opcode == OP_ADD || i_opcode == OP_SUB) ? SEL_ADD :
                        (i_opcode == OP_AND) ? SEL_AND :
                        (i_opcode == OP_OR)  ? SEL_OR  : SEL_FWD;
        o_negate_src2 = i_opcode == OP_SUB;
        o_use_imm     = i_opcode == OP_LOADI;
        o_zero_src1   = i_opcode == OP_LOADI || i_opcode == OP_MOV;
        o_wait_cycles = (o_alu_select == SEL_ADD) ? CNT_W'(ADD_WAIT) :
                        (o_alu_select == SEL_FWD) ? CNT_W'(FWD_WAIT) : CNT_W'(LOGIC_WAIT);
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller running one ALU instruction at a time
// through IDLE -> DECODE -> EXEC (ALU settling) -> WRITE.
module alu_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int FWD_WAIT   = 1,
    parameter int ADD_WAIT   = 2,
    parameter int LOGIC_WAIT = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        INSTR_VALID,
    input  logic [31:0] INSTRUCTION,
    output logic        INSTR_READY,
    output logic [2:0]  READREG1,
    output logic [2:0]  READREG2,
    input  logic [7:0]  REGOUT1,
    input  logic [7:0]  REGOUT2,
    output logic [7:0]  ALU_DATA1,
    output logic [7:0]  ALU_DATA2,
    output logic [2:0]  ALU_SELECT,
    input  logic [7:0]  ALU_RESULT,
    output logic [2:0]  WRITEREG,
    output logic [7:0]  WRITEDATA,
    output logic        WRITEENABLE,
    output logic        BUSY,
    output logic        ILLEGAL_OP
);
    state_e           r_state, w_next;
    logic [7:0]       r_op, r_imm, r_data1, r_data2, r_wdata;
    logic [2:0]       r_dest, r_src1;
    logic [CNT_W-1:0] r_cnt, w_wait;
    alu_sel_e         r_sel, w_sel;
    logic             r_illegal, w_neg, w_imm, w_zero, w_illegal, w_unused;

    assign w_unused = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

    alu_op_decoder #(
        .FWD_WAIT  (FWD_WAIT),
        .ADD_WAIT  (ADD_WAIT),
        .LOGIC_WAIT(LOGIC_WAIT)
    ) u_dec (
        .i_opcode     (r_op),
        .o_alu_select (w_sel),
        .o_negate_src2(w_neg),
        .o_use_imm    (w_imm),
        .o_zero_src1  (w_zero),
        .o_wait_cycles(w_wait),
        .o_illegal    (w_illegal)
    );

    always_ff @(posedge CLK)
        r_state <= RESET ? S_IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = INSTR_VALID ? S_DECODE : S_IDLE;
            S_DECODE: w_next = w_illegal ? S_IDLE : S_EXEC;
            S_EXEC:   w_next = (r_cnt == CNT_W'(1)) ? S_WRITE : S_EXEC;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        INSTR_READY = r_state == S_IDLE;
        BUSY        = r_state != S_IDLE;
        WRITEENABLE = r_state == S_WRITE;
        ILLEGAL_OP  = r_illegal;
        READREG1    = r_src1;
        READREG2    = r_imm[2:0];
        WRITEREG    = r_dest;
        ALU_DATA1   = r_data1;
        ALU_DATA2   = r_data2;
        ALU_SELECT  = r_sel;
        WRITEDATA   = r_wdata;
    end

    // operands and select only move on the DECODE->EXEC edge so the ALU sees stable inputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_op      <= '0;
            r_imm     <= '0;
            r_dest    <= '0;
            r_src1    <= '0;
            r_data1   <= '0;
            r_data2   <= '0;
            r_sel     <= SEL_FWD;
            r_cnt     <= '0;
            r_wdata   <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (r_state == S_IDLE && INSTR_VALID) begin
                r_op   <= INSTRUCTION[31:24];
                r_dest <= INSTRUCTION[18:16];
                r_src1 <= INSTRUCTION[10:8];
                r_imm  <= INSTRUCTION[7:0];
            end
            if (r_state == S_DECODE && !w_illegal) begin
                r_data1 <= w_zero ? 8'h00 : REGOUT1;
                r_data2 <= w_imm ? r_imm : w_neg ? -REGOUT2 : REGOUT2;
                r_sel   <= w_sel;
                r_cnt   <= w_wait;
            end
            if (r_state == S_EXEC) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1))
                    r_wdata <= ALU_RESULT;
            end
            r_illegal <= r_state == S_DECODE && w_illegal;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random instructions against a register-file/ALU
// model with per-operation settling delay and an architectural reference.
module tb_alu_sequencer;
    localparam int FW = 1, AW = 2, LW = 1;

    logic        CLK = 1'b0, RESET = 1'b1, INSTR_VALID = 1'b0;
    logic [31:0] INSTRUCTION = '0;
    logic        INSTR_READY, WRITEENABLE, BUSY, ILLEGAL_OP;
    logic [2:0]  READREG1, READREG2, ALU_SELECT, WRITEREG;
    logic [7:0]  REGOUT1, REGOUT2, ALU_DATA1, ALU_DATA2, ALU_RESULT, WRITEDATA;

    alu_sequencer #(.FWD_WAIT(FW), .ADD_WAIT(AW), .LOGIC_WAIT(LW)) dut (
        .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .INSTRUCTION(INSTRUCTION),
        .INSTR_READY(INSTR_READY), .READREG1(READREG1), .READREG2(READREG2),
        .REGOUT1(REGOUT1), .REGOUT2(REGOUT2), .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2),
        .ALU_SELECT(ALU_SELECT), .ALU_RESULT(ALU_RESULT), .WRITEREG(WRITEREG),
        .WRITEDATA(WRITEDATA), .WRITEENABLE(WRITEENABLE), .BUSY(BUSY), .ILLEGAL_OP(ILLEGAL_OP)
    );

    always #5 CLK = ~CLK;

    logic [7:0] rf [8];
    logic [7:0] mreg [8];
    always @(posedge CLK) if (WRITEENABLE) rf[WRITEREG] <= WRITEDATA;
    assign REGOUT1 = rf[READREG1];
    assign REGOUT2 = rf[READREG2];

    // ALU gives a wrong value until its inputs have been stable for its latency
    logic [18:0] prev_in = '0;
    int          stab = 0;
    logic [7:0]  alu_val;
    always @(negedge CLK) begin
        if ({ALU_SELECT, ALU_DATA1, ALU_DATA2} !== prev_in) stab = 1;
        else if (stab < 1000) stab++;
        prev_in = {ALU_SELECT, ALU_DATA1, ALU_DATA2};
    end
    always_comb begin
        alu_val = (ALU_SELECT == 3'b001) ? ALU_DATA1 + ALU_DATA2 :
                  (ALU_SELECT == 3'b010) ? ALU_DATA1 & ALU_DATA2 :
                  (ALU_SELECT == 3'b011) ? ALU_DATA1 | ALU_DATA2 : ALU_DATA2;
        ALU_RESULT = (stab >= ((ALU_SELECT == 3'b001) ? 2 : 1)) ? alu_val : ~alu_val;
    end

    int ncmp = 0, nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [7:0] s2);
        return {op, 5'b0, d, 5'b0, s1, s2};
    endfunction

    function automatic int wait_of(input logic [7:0] op);
        return (op == 2 || op == 3) ? AW : (op == 4 || op == 5) ? LW : FW;
    endfunction

    function automatic logic [7:0] ref_res(input logic [7:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] imm);
        case (op)
            8'h00:   return imm;
            8'h01:   return b;
            8'h02:   return 8'((int'(a) + int'(b)) % 256);
            8'h03:   return 8'((int'(a) - int'(b) + 256) % 256);
            8'h04:   return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [2:0] ref_sel(input logic [7:0] op);
        return (op == 2 || op == 3) ? 3'b001 : (op == 4) ? 3'b010 : (op == 5) ? 3'b011 : 3'b000;
    endfunction

    task automatic run(input logic [31:0] w, input string tag);
        logic [7:0] op, imm, a, b, exp, wd, d1, d2;
        logic [2:0] dest, wr, sel;
        logic       legal, rdy_end;
        int wt, win, we_n, we_c, il_n, il_c, busy_bad, g;
        op = w[31:24]; dest = w[18:16]; imm = w[7:0];
        a = mreg[w[10:8]]; b = mreg[w[2:0]];
        legal = op <= 8'h05; wt = wait_of(op); win = legal ? 3 + wt : 2;
        exp = ref_res(op, a, b, imm);
        we_n = 0; we_c = -1; il_n = 0; il_c = -1; busy_bad = 0; g = 0;
        wd = '0; d1 = '0; d2 = '0; wr = '0; sel = '0; rdy_end = 1'b0;
        INSTR_VALID = 1'b1; INSTRUCTION = w;
        while (!INSTR_READY && g < 50) begin @(negedge CLK); g++; end
        chk({tag, " ready"}, INSTR_READY, 1);
        @(posedge CLK);
        for (int c = 1; c <= win; c++) begin
            @(negedge CLK);
            if (c == 1) INSTR_VALID = 1'b0;
            if (WRITEENABLE) begin
                we_n++; we_c = c; wd = WRITEDATA; wr = WRITEREG;
                sel = ALU_SELECT; d1 = ALU_DATA1; d2 = ALU_DATA2;
            end
            if (ILLEGAL_OP) begin il_n++; il_c = c; end
            if (c < win && !BUSY) busy_bad++;
            if (c == win) rdy_end = INSTR_READY;
        end
        if (legal) begin
            chk({tag, " we_count"}, we_n, 1);
            chk({tag, " we_cycle"}, we_c, 2 + wt);
            chk({tag, " writereg"}, wr, dest);
            chk({tag, " writedata"}, wd, exp);
            chk({tag, " select"}, sel, ref_sel(op));
            chk({tag, " data1"}, d1, (op <= 1) ? 8'h00 : a);
            chk({tag, " data2"}, d2, (op == 0) ? imm : (op == 3) ? 8'(256 - int'(b)) : b);
            chk({tag, " illegal"}, il_n, 0);
            mreg[dest] = exp;
        end else begin
            chk({tag, " illegal_count"}, il_n, 1);
            chk({tag, " illegal_cycle"}, il_c, 2);
            chk({tag, " no_write"}, we_n, 0);
        end
        chk({tag, " busy"}, busy_bad, 0);
        chk({tag, " ready_end"}, rdy_end, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w, bw [3];
        logic [7:0]  exps [3], op;
        int acc [3], k_acc, we_n, r;
        logic chg;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        chk("rst ready", INSTR_READY, 1);
        chk("rst busy", BUSY, 0);
        chk("rst we", WRITEENABLE, 0);
        chk("rst illegal", ILLEGAL_OP, 0);
        chk("rst outs", {ALU_DATA1, ALU_DATA2, ALU_SELECT, WRITEDATA, WRITEREG, READREG1, READREG2}, 0);

        for (int i = 0; i < 8; i++) run(enc(8'h00, 3'(i), 3'($urandom), 8'($urandom)), "init");
        run(enc(8'h00, 3, 0, 8'h5A), "loadi");
        chk("loadi rf3", rf[3], 8'h5A);
        run(enc(8'h00, 1, 0, 8'hF0), "ld1");
        run(enc(8'h00, 2, 0, 8'h20), "ld2");
        run(enc(8'h02, 7, 1, 8'h02), "add");
        chk("add rf7", rf[7], 8'h10);
        run(enc(8'h00, 1, 0, 8'h05), "ld1b");
        run(enc(8'h00, 2, 0, 8'h07), "ld2b");
        run(enc(8'h03, 0, 1, 8'h02), "sub");
        chk("sub rf0", rf[0], 8'hFE);
        run(enc(8'h09, 5, 1, 8'h02), "illegal09");
        run(enc(8'h01, 6, 0, 8'h03), "mov_after_illegal");

        INSTR_VALID = 1'b1; INSTRUCTION = enc(8'h02, 4, 1, 8'h02);
        @(posedge CLK); @(negedge CLK); INSTR_VALID = 1'b0;
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK); RESET = 1'b0;
        chk("midrst ready", INSTR_READY, 1);
        chk("midrst busy", BUSY, 0);
        chk("midrst we", WRITEENABLE, 0);
        chk("midrst outs", {ALU_DATA1, ALU_DATA2, ALU_SELECT, WRITEDATA, WRITEREG, READREG1, READREG2}, 0);
        we_n = 0;
        repeat (5) begin @(negedge CLK); if (WRITEENABLE) we_n++; end
        chk("midrst no_write", we_n, 0);
        run(enc(8'h00, 4, 0, 8'hCC), "ld4");
        run(enc(8'h00, 5, 0, 8'h0F), "ld5");
        run(enc(8'h04, 6, 4, 8'h05), "and");
        chk("and rf6", rf[6], 8'h0C);

        bw[0] = enc(8'h05, 1, 4, 8'h05);
        bw[1] = enc(8'h05, 2, 1, 8'h06);
        bw[2] = enc(8'h05, 3, 2, 8'h07);
        for (int k = 0; k < 3; k++) begin
            exps[k] = mreg[bw[k][10:8]] | mreg[bw[k][2:0]];
            mreg[bw[k][18:16]] = exps[k];
            acc[k] = -1;
        end
        k_acc = 0; we_n = 0; chg = 1'b0;
        INSTRUCTION = bw[0]; INSTR_VALID = 1'b1;
        for (int t = 0; t <= 12; t++) begin
            if (t > 0) @(negedge CLK);
            if (chg) begin
                chg = 1'b0;
                if (k_acc < 3) INSTRUCTION = bw[k_acc]; else INSTR_VALID = 1'b0;
            end
            if (WRITEENABLE) begin
                if (we_n < 3) chk("b2b writedata", WRITEDATA, exps[we_n]);
                we_n++;
            end
            if (INSTR_VALID && INSTR_READY) begin
                chk("b2b busy_at_accept", BUSY, 0);
                if (k_acc < 3) acc[k_acc] = t;
                k_acc++; chg = 1'b1;
            end
        end
        chk("b2b accepts", k_acc, 3);
        chk("b2b acc0", acc[0], 0);
        chk("b2b acc1", acc[1], 4);
        chk("b2b acc2", acc[2], 8);
        chk("b2b we_count", we_n, 3);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 7));
            op = (r < 6) ? 8'(r) : 8'($urandom_range(6, 255));
            w = $urandom;
            w[31:24] = op;
            run(w, "rand");
        end

        for (int i = 0; i < 8; i++) chk($sformatf("final rf%0d", i), rf[i], mreg[i]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
